fnd_scan_driver: RTL

Time-multiplexed driver for an N-digit common-anode 7-segment (FND) display. It takes packed hex nibbles and per-digit decimal points, then scans one digit at a time at a programmable rate. Each nibble is encoded to segment patterns internally. Writes are double-buffered so an update never lands mid-frame, and leading-zero blanking is optional. The block sits between datapath results (counters, multiplier outputs) and the board's FND pins.

---
 rtl/fnd_pkg.sv | 28 ++
 rtl/fnd_scan_driver_if.sv | 38 +++
 rtl/fnd_seg_lut.sv | 17 +
 rtl/fnd_scan_driver.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the FND scan driver: segment encoding
// table, off/inactive levels per polarity, and width helpers.
package fnd_pkg;

  // Hex nibble -> segment pattern, bit order {g,f,e,d,c,b,a}, 1 = lit.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Pin level that leaves every segment dark for the given polarity.
  function automatic logic [6:0] seg_off(input bit act_low);
    return act_low ? 7'h7F : 7'h00;
  endfunction

  // Level of one inactive digit-common pin; callers replicate to the
  // digit count.
  function automatic logic com_off(input bit act_low);
    return act_low;
  endfunction

  // Width able to index n items; never below 1 so single-item cases
  // still produce a legal vector.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fnd_scan_driver_if.sv
// Bus between a data source and the FND scan driver, plus the pin side
// and a small debug view of internal state.
//
// Handshake: load is a single-cycle strobe with no ready; the driver
// accepts it on every clock edge where it is high, capturing data_in and
// dp_in in that same edge. Repeated strobes before the frame boundary
// overwrite each other; the last one wins.
interface fnd_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  import fnd_pkg::*;

  localparam int IDX_W = idx_width(NUM_DIGITS);

  logic                      load;
  logic [4*NUM_DIGITS-1:0]   data_in;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic                      lz_blank;

  logic [6:0]                seg;
  logic                      dp;
  logic [NUM_DIGITS-1:0]     com;
  logic                      frame_done;

  logic                      dbg_pending;
  logic [IDX_W-1:0]          dbg_index;

  modport master (
    output load, data_in, dp_in, lz_blank,
    input  seg, dp, com, frame_done, dbg_pending, dbg_index
  );

  modport slave (
    input  load, data_in, dp_in, lz_blank,
    output seg, dp, com, frame_done, dbg_pending, dbg_index
  );

endinterface

// File: rtl/fnd_seg_lut.sv
// Combinational hex-to-7-segment encoder with a blanking override.
// Output is active-high; polarity is applied by the caller.
module fnd_seg_lut
  import fnd_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] pattern
);

  // Table lookup, forced dark when the digit is blanked.
  always_comb begin
    pattern = SEG_LUT[nibble];
    if (blank) pattern = 7'h00;
  end

endmodule

// File: rtl/fnd_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver. One digit is enabled per
// slot of SCAN_DIV cycles, with the first cycle of every slot left dark
// to avoid ghosting. New data is held in a shadow register and promoted
// to the displayed register only at the end of a frame.
module fnd_scan_driver
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 50000,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit COM_ACT_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  fnd_scan_driver_if.slave bus
);

  localparam int DW    = 4 * NUM_DIGITS;
  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam int CNT_W = idx_width(SCAN_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Scan position
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  slot_end, boundary;

  // Double buffer
  logic [DW-1:0]         shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic                  pending_q, pending_d;
  logic [DW-1:0]         active_q, active_d;
  logic [NUM_DIGITS-1:0] active_dp_q, active_dp_d;

  // Registered pins
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] com_q, com_d;
  logic                  frame_done_q, frame_done_d;

  // Display datapath
  logic [DW-1:0]         shifted;
  logic [3:0]            nibble;
  logic                  blank;
  logic                  dp_lit;
  logic [NUM_DIGITS-1:0] com_on;
  logic [6:0]            pattern;

  // Slot counter and digit index; boundary marks the last cycle of a frame.
  always_comb begin
    slot_end = (cnt_q == CNT_LAST);
    boundary = slot_end && (idx_q == IDX_LAST);
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

  // Shadow capture on load; promotion to active at the frame boundary.
  // A load landing on the boundary itself bypasses the shadow.
  always_comb begin
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    pending_d   = pending_q;
    active_d    = active_q;
    active_dp_d = active_dp_q;
    if (bus.load) begin
      if (boundary) begin
        active_d    = bus.data_in;
        active_dp_d = bus.dp_in;
        pending_d   = 1'b0;
      end else begin
        shadow_d    = bus.data_in;
        shadow_dp_d = bus.dp_in;
        pending_d   = 1'b1;
      end
    end else if (boundary && pending_q) begin
      active_d    = shadow_q;
      active_dp_d = shadow_dp_q;
      pending_d   = 1'b0;
    end
  end

  // Select the current digit, decide leading-zero blanking, build pin levels.
  // A digit is a leading zero when it and every higher nibble are zero.
  always_comb begin
    shifted      = active_q >> {idx_q, 2'b00};
    nibble       = shifted[3:0];
    blank        = bus.lz_blank && (idx_q != '0) && (shifted == '0);
    dp_lit       = active_dp_q[idx_q] & ~blank;
    com_on       = (cnt_q != '0) ? (NUM_DIGITS'(1) << idx_q) : '0;
    seg_d        = SEG_ACT_LOW ? ~pattern : pattern;
    dp_d         = SEG_ACT_LOW ? ~dp_lit : dp_lit;
    com_d        = COM_ACT_LOW ? ~com_on : com_on;
    frame_done_d = boundary;
  end

  fnd_seg_lut u_lut (
    .nibble  (nibble),
    .blank   (blank),
    .pattern (pattern)
  );

  // State and output registers; reset drives all pins to their dark level.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      active_q     <= '0;
      active_dp_q  <= '0;
      seg_q        <= seg_off(SEG_ACT_LOW);
      dp_q         <= SEG_ACT_LOW;
      com_q        <= {NUM_DIGITS{com_off(COM_ACT_LOW)}};
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      active_q     <= active_d;
      active_dp_q  <= active_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      com_q        <= com_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.com         = com_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.dbg_pending = pending_q;
  assign bus.dbg_index   = idx_q;

endmodule
